mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access (MA) pipeline stage. Sits between the execute stage and the write-back stage; produces the 70-bit MA-to-WB bus.
- Latches the EX-to-MA bus using the valid/allowin double handshake.
- Merges synchronous data-SRAM read data and applies load byte/half selection with sign or zero extension.
- Drives a forwarding/hazard bus back to decode.

Parameters:
- BUS_EX_W, 74, width of ex_to_ma_bus (fixed by field layout; not for override).
- BUS_WB_W, 70, width of ma_to_wb_bus (fixed; must match write-back stage).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- ex_validout  in  1  EX holds a valid instruction ready to send.
- wb_allowin  in  1  WB can accept data this cycle.
- ma_allowin  out  1  MA can accept data this cycle.
- ma_validout  out  1  MA holds a valid, completed instruction.
- ex_to_ma_bus  in  74  EX-to-MA bus fields:
  - [73:71] ld_type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU.
  - [70] res_from_mem.
  - [69] gr_we.
  - [68:64] dest.
  - [63:32] alu_result (holds the address for loads).
  - [31:0] pc.
- data_sram_rdata  in  32  read data for the request issued by EX in the previous cycle.
- ma_to_wb_bus  out  70  MA-to-WB bus fields: [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc.
- ma_fwd_bus  out  38  forwarding bus fields: [37] fwd_we, [36:32] dest, [31:0] final_result.

Behaviour:
- Reset (async, takes effect immediately): valid=0; bus register=0.
  - Consequently ma_validout=0, ma_to_wb_bus=0, ma_fwd_bus=0, ma_allowin=1.
- Reset applies mid-operation too: an in-flight instruction is discarded with no write-back.
- readygo is constant 1 (single-cycle MA; SRAM data arrives in the MA cycle).
- ma_allowin = ~valid | (readygo & wb_allowin).
- ma_validout = valid & readygo.
- valid update, on posedge when ma_allowin=1: valid <= ex_validout. Otherwise valid holds.
- Bus register update, on posedge when ex_validout & ma_allowin: load ex_to_ma_bus. Otherwise hold; this includes the stall case where valid=1 and wb_allowin=0.
- Stalled instruction: the same instruction stays in MA across stall cycles. data_sram_rdata must be held stable by the surrounding design for those cycles; MA does not re-sample or buffer it.
- Load extraction uses a = alu_result[1:0]:
  - byte = rdata[8a+7 : 8a].
  - half = a[1] ? rdata[31:16] : rdata[15:0].
  - a[0] is ignored for halves; there is no misalignment exception.
- mem_result by ld_type:
  - LW: rdata.
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend half.
  - LHU: zero-extend half.
  - Reserved codes 101–111: treated as LW.
- final_result = res_from_mem ? mem_result : alu_result.
- ma_to_wb_bus:
  - gr_we bit = gr_we & valid, so a bubble never writes.
  - dest, final_result and pc are driven straight from the register and mux.
- ma_fwd_bus:
  - fwd_we = gr_we & valid.
  - dest and final_result are the same values as in ma_to_wb_bus.
  - Purely combinational from current MA contents.
- Simultaneous leave and enter (valid=1, wb_allowin=1, ex_validout=1): the new instruction replaces the old one in the same edge. Back-to-back throughput is one instruction per cycle.
- Drain (valid=1, wb_allowin=1, ex_validout=0): valid goes to 0 and the bus register holds its stale contents; gr_we and fwd_we go low.
- dest=0 is passed through unchanged; the register file ignores r0.

Test Plan:
1. Reset check: assert rst asynchronously mid-cycle while valid=1 → ma_validout and ma_to_wb_bus go to 0 before the next edge; ma_allowin=1.
2. ALU passthrough: ex_to_ma_bus with res_from_mem=0, gr_we=1, dest=5, alu_result=0x1234_5678, pc=0x1C00_0000, wb_allowin=1 → after 1 edge, ma_to_wb_bus = {1,5,0x12345678,0x1C000000} and ma_fwd_bus = {1,5,0x12345678}.
3. Load extension with rdata=0x80FF_7F01:
   - LB, a=3 → 0xFFFF_FF80.
   - LBU, a=1 → 0x0000_007F.
   - LH, a=2 → 0xFFFF_80FF.
   - LHU, a=0 → 0x0000_7F01.
   - LW → 0x80FF_7F01.
   - ld_type=111 → 0x80FF_7F01.
4. WB stall: hold wb_allowin=0 for 3 cycles with ex_validout=1 and a changing ex_to_ma_bus → ma_allowin=0, ma_to_wb_bus unchanged for all 3 cycles. On release, the next instruction is latched at the first edge after release.
5. Back-to-back streaming: 4 instructions with ex_validout=1 continuously and wb_allowin=1 → ma_validout=1 for 4 consecutive cycles, with pcs in order and none duplicated or lost.
6. Bubble: ex_validout=0 with gr_we=1 in the stale register → gr_we bit and fwd_we are both 0, and ma_validout=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EX-to-MA bus via a valid/allowin
// handshake, merges synchronous data-SRAM read data with load byte/half
// extraction, and drives the MA-to-WB bus plus a forwarding bus to decode.
module mem_stage #(
  parameter int BUS_EX_W = 74,
  parameter int BUS_WB_W = 70
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_validout,
  input  logic                wb_allowin,
  output logic                ma_allowin,
  output logic                ma_validout,
  input  logic [BUS_EX_W-1:0] ex_to_ma_bus,
  input  logic [31:0]         data_sram_rdata,
  output logic [BUS_WB_W-1:0] ma_to_wb_bus,
  output logic [37:0]         ma_fwd_bus
);

  localparam logic [2:0] LD_W   = 3'b000;
  localparam logic [2:0] LD_B   = 3'b001;
  localparam logic [2:0] LD_BU  = 3'b010;
  localparam logic [2:0] LD_H   = 3'b011;
  localparam logic [2:0] LD_HU  = 3'b100;

  // SRAM data arrives in the MA cycle, so MA always completes in one cycle.
  localparam logic READYGO = 1'b1;

  logic                vld_p0;
  logic [BUS_EX_W-1:0] bus_p0;

  logic [2:0]  ld_type;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [1:0]  addr_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] mem_result;
  logic [31:0] final_result;
  logic        we_qual;

  function automatic logic signed [31:0] sext_byte(input logic signed [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic signed [31:0] sext_half(input logic signed [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  function automatic logic [31:0] zext_byte(input logic [7:0] b);
    return {24'd0, b};
  endfunction

  function automatic logic [31:0] zext_half(input logic [15:0] h);
    return {16'd0, h};
  endfunction

  assign ma_allowin  = ~vld_p0 | (READYGO & wb_allowin);
  assign ma_validout = vld_p0 & READYGO;

  // ---- EX -> MA boundary ----
  // Valid flag: advances whenever MA can accept, otherwise holds through a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p0 <= 1'b0;
    else if (ma_allowin)
      vld_p0 <= ex_validout;
  end

  // Instruction register: captures only on an accepted transfer; stale on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus_p0 <= '0;
    else if (ex_validout && ma_allowin)
      bus_p0 <= ex_to_ma_bus;
  end

  assign ld_type      = bus_p0[73:71];
  assign res_from_mem = bus_p0[70];
  assign gr_we        = bus_p0[69];
  assign dest         = bus_p0[68:64];
  assign alu_result   = bus_p0[63:32];
  assign pc           = bus_p0[31:0];
  assign addr_lo      = alu_result[1:0];

  // Byte/half lane selection from the low address bits; a[0] ignored for halves.
  always_comb begin
    ld_byte = data_sram_rdata[7:0];
    case (addr_lo)
      2'd0: ld_byte = data_sram_rdata[7:0];
      2'd1: ld_byte = data_sram_rdata[15:8];
      2'd2: ld_byte = data_sram_rdata[23:16];
      2'd3: ld_byte = data_sram_rdata[31:24];
      default: ld_byte = data_sram_rdata[7:0];
    endcase
    ld_half = addr_lo[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
  end

  // Load extension; reserved encodings fall back to a full-word load.
  always_comb begin
    mem_result = data_sram_rdata;
    case (ld_type)
      LD_W:    mem_result = data_sram_rdata;
      LD_B:    mem_result = sext_byte(ld_byte);
      LD_BU:   mem_result = zext_byte(ld_byte);
      LD_H:    mem_result = sext_half(ld_half);
      LD_HU:   mem_result = zext_half(ld_half);
      default: mem_result = data_sram_rdata;
    endcase
  end

  assign final_result = res_from_mem ? mem_result : alu_result;

  // A bubble or drained slot must never write the register file or forward.
  assign we_qual = gr_we & vld_p0;

  assign ma_to_wb_bus = {we_qual, dest, final_result, pc};
  assign ma_fwd_bus   = {we_qual, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU passthrough, load extension,
// WB stall, back-to-back streaming, drain/bubble and asynchronous reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_validout;
  logic        wb_allowin;
  logic        ma_allowin;
  logic        ma_validout;
  logic [73:0] ex_to_ma_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] ma_to_wb_bus;
  logic [37:0] ma_fwd_bus;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_validout     (ex_validout),
    .wb_allowin      (wb_allowin),
    .ma_allowin      (ma_allowin),
    .ma_validout     (ma_validout),
    .ex_to_ma_bus    (ex_to_ma_bus),
    .data_sram_rdata (data_sram_rdata),
    .ma_to_wb_bus    (ma_to_wb_bus),
    .ma_fwd_bus      (ma_fwd_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [73:0] mk(input logic [2:0] ld, input logic rfm,
                                     input logic we, input logic [4:0] d,
                                     input logic [31:0] alu, input logic [31:0] p);
    return {ld, rfm, we, d, alu, p};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    ex_validout     = 1'b0;
    wb_allowin      = 1'b1;
    ex_to_ma_bus    = '0;
    data_sram_rdata = 32'h80FF_7F01;
    #2;
    chk("rst_validout", 70'(ma_validout), 70'(1'b0));
    chk("rst_wb_bus",   ma_to_wb_bus, 70'd0);
    chk("rst_fwd_bus",  70'(ma_fwd_bus), 70'd0);
    chk("rst_allowin",  70'(ma_allowin), 70'(1'b1));
    rst = 1'b0;

    // ALU passthrough
    ex_validout  = 1'b1;
    ex_to_ma_bus = mk(3'b000, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000);
    step();
    chk("alu_validout", 70'(ma_validout), 70'(1'b1));
    chk("alu_wb_bus", ma_to_wb_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000});
    chk("alu_fwd_bus", 70'(ma_fwd_bus), 70'({1'b1, 5'd5, 32'h1234_5678}));

    // Load extension, rdata = 0x80FF7F01
    ex_to_ma_bus = mk(3'b001, 1'b1, 1'b1, 5'd7, 32'h0000_1003, 32'h1C00_0010);
    step();
    chk("lb_a3", 70'(ma_to_wb_bus[63:32]), 70'(32'hFFFF_FF80));
    ex_to_ma_bus = mk(3'b010, 1'b1, 1'b1, 5'd7, 32'h0000_1001, 32'h1C00_0014);
    step();
    chk("lbu_a1", 70'(ma_to_wb_bus[63:32]), 70'(32'h0000_007F));
    ex_to_ma_bus = mk(3'b011, 1'b1, 1'b1, 5'd7, 32'h0000_1002, 32'h1C00_0018);
    step();
    chk("lh_a2", 70'(ma_to_wb_bus[63:32]), 70'(32'hFFFF_80FF));
    ex_to_ma_bus = mk(3'b100, 1'b1, 1'b1, 5'd7, 32'h0000_1000, 32'h1C00_001C);
    step();
    chk("lhu_a0", 70'(ma_to_wb_bus[63:32]), 70'(32'h0000_7F01));
    ex_to_ma_bus = mk(3'b000, 1'b1, 1'b1, 5'd7, 32'h0000_1000, 32'h1C00_0020);
    step();
    chk("lw", 70'(ma_to_wb_bus[63:32]), 70'(32'h80FF_7F01));
    ex_to_ma_bus = mk(3'b111, 1'b1, 1'b1, 5'd7, 32'h0000_1003, 32'h1C00_0024);
    step();
    chk("ld_rsvd", 70'(ma_to_wb_bus[63:32]), 70'(32'h80FF_7F01));
    chk("ld_rsvd_full", ma_to_wb_bus, {1'b1, 5'd7, 32'h80FF_7F01, 32'h1C00_0024});
    // extra lanes: LB a=0 positive, LH a=1 uses low half
    ex_to_ma_bus = mk(3'b001, 1'b1, 1'b1, 5'd7, 32'h0000_1000, 32'h1C00_0028);
    step();
    chk("lb_a0", 70'(ma_to_wb_bus[63:32]), 70'(32'h0000_0001));
    ex_to_ma_bus = mk(3'b011, 1'b1, 1'b1, 5'd7, 32'h0000_1001, 32'h1C00_002C);
    step();
    chk("lh_a1", 70'(ma_to_wb_bus[63:32]), 70'(32'h0000_7F01));
    ex_to_ma_bus = mk(3'b010, 1'b1, 1'b1, 5'd7, 32'h0000_1002, 32'h1C00_0030);
    step();
    chk("lbu_a2", 70'(ma_to_wb_bus[63:32]), 70'(32'h0000_00FF));

    // WB stall: instruction A held for 3 cycles
    ex_to_ma_bus = mk(3'b000, 1'b0, 1'b1, 5'd3, 32'hAAAA_0000, 32'h0000_0100);
    step();
    chk("stall_a_in", ma_to_wb_bus, {1'b1, 5'd3, 32'hAAAA_0000, 32'h0000_0100});
    wb_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_to_ma_bus = mk(3'b000, 1'b0, 1'b1, 5'd9, 32'hBBBB_0000 + 32'(i), 32'h0000_0104 + 32'(4 * i));
      #1;
      chk($sformatf("stall_allowin_%0d", i), 70'(ma_allowin), 70'(1'b0));
      step();
      chk($sformatf("stall_hold_%0d", i), ma_to_wb_bus, {1'b1, 5'd3, 32'hAAAA_0000, 32'h0000_0100});
      chk($sformatf("stall_valid_%0d", i), 70'(ma_validout), 70'(1'b1));
    end
    wb_allowin   = 1'b1;
    ex_to_ma_bus = mk(3'b000, 1'b0, 1'b1, 5'd4, 32'hEEEE_0000, 32'h0000_0180);
    #1;
    chk("release_allowin", 70'(ma_allowin), 70'(1'b1));
    step();
    chk("release_latch", ma_to_wb_bus, {1'b1, 5'd4, 32'hEEEE_0000, 32'h0000_0180});

    // Back-to-back streaming of 4 instructions
    for (int i = 0; i < 4; i++) begin
      ex_to_ma_bus = mk(3'b000, 1'b0, 1'b1, 5'(10 + i), 32'h5000_0000 + 32'(i), 32'h0000_0200 + 32'(4 * i));
      step();
      chk($sformatf("stream_valid_%0d", i), 70'(ma_validout), 70'(1'b1));
      chk($sformatf("stream_pc_%0d", i), 70'(ma_to_wb_bus[31:0]), 70'(32'h0000_0200 + 32'(4 * i)));
    end

    // Drain / bubble: stale register with gr_we=1
    ex_validout  = 1'b0;
    ex_to_ma_bus = mk(3'b000, 1'b0, 1'b1, 5'd20, 32'h6666_0000, 32'h0000_0300);
    step();
    chk("bubble_validout", 70'(ma_validout), 70'(1'b0));
    chk("bubble_wb_bus", ma_to_wb_bus, {1'b0, 5'd13, 32'h5000_0003, 32'h0000_020C});
    chk("bubble_fwd_we", 70'(ma_fwd_bus[37]), 70'(1'b0));
    chk("bubble_allowin", 70'(ma_allowin), 70'(1'b1));
    wb_allowin = 1'b0;
    #1;
    chk("bubble_allowin_wbstall", 70'(ma_allowin), 70'(1'b1));
    wb_allowin = 1'b1;

    // Asynchronous mid-cycle reset with a valid instruction in MA
    ex_validout  = 1'b1;
    ex_to_ma_bus = mk(3'b000, 1'b0, 1'b1, 5'd8, 32'h7777_0000, 32'h0000_0400);
    step();
    chk("prerst_valid", 70'(ma_validout), 70'(1'b1));
    ex_validout = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_validout", 70'(ma_validout), 70'(1'b0));
    chk("arst_wb_bus", ma_to_wb_bus, 70'd0);
    chk("arst_fwd_bus", 70'(ma_fwd_bus), 70'd0);
    chk("arst_allowin", 70'(ma_allowin), 70'(1'b1));
    rst = 1'b0;
    step();
    chk("postrst_validout", 70'(ma_validout), 70'(1'b0));
    chk("postrst_wb_bus", ma_to_wb_bus, 70'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
